// File: rtl/wb_splitter_pipelined.sv
// Registered Wishbone B4 classic 1-to-N splitter: address decode, response timeout,
// unmapped-address errors and a sticky first-fault capture register.
module wb_splitter_pipelined #(
    parameter int NUM_PERIPHERALS  = 27,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SEL_WIDTH        = 4,
    parameter int ADDR_SEL_LOW_BIT = 16,
    parameter int ADDR_SEL_BITS    = 5,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_i,
    input  logic                                  m_wb_cyc_i,
    input  logic                                  m_wb_stb_i,
    input  logic                                  m_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
    output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
    output logic                                  m_wb_ack_o,
    output logic                                  m_wb_err_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
    output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
    output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
    input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
    output logic                                  fault_valid_o,
    output logic [1:0]                            fault_code_o,
    output logic [ADDR_WIDTH-1:0]                 fault_adr_o,
    input  logic                                  fault_clr_i
);

    localparam int IDX_W = ADDR_SEL_BITS;
    // The counter runs 0..TIMEOUT_CYCLES-1 across the BUSY cycles, so the last
    // BUSY cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IDX_W:0] NUM_P = (IDX_W + 1)'(NUM_PERIPHERALS);

    localparam logic [1:0] FC_UNMAPPED = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_SLVERR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  fault_valid_q, fault_valid_d;
    logic [1:0]            fault_code_q, fault_code_d;
    logic [ADDR_WIDTH-1:0] fault_adr_q, fault_adr_d;

    logic                  fault_set;
    logic [1:0]            fault_set_code;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_mapped;
    logic                  busy;
    logic                  sel_ack, sel_err;
    logic [DATA_WIDTH-1:0] sel_dat;

    assign req_idx    = m_wb_adr_i[ADDR_SEL_LOW_BIT +: IDX_W];
    assign req_mapped = ({1'b0, req_idx} < NUM_P);
    assign busy       = (state_q == ST_BUSY);

    // Only the selected slave's response is observed; all others are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_PERIPHERALS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack = s_wb_ack_i[i];
                sel_err = s_wb_err_i[i];
                sel_dat = s_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PERIPHERALS; gi++) begin : g_slave
            logic hit;
            assign hit            = busy && (idx_q == IDX_W'(gi));
            assign s_wb_cyc_o[gi] = hit;
            assign s_wb_stb_o[gi] = hit;
            assign s_wb_we_o[gi]  = hit && we_q;
            assign s_wb_adr_o[gi*ADDR_WIDTH +: ADDR_WIDTH] = adr_q;
            assign s_wb_dat_o[gi*DATA_WIDTH +: DATA_WIDTH] = dat_q;
            assign s_wb_sel_o[gi*SEL_WIDTH +: SEL_WIDTH]   = sel_q;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        adr_d          = adr_q;
        dat_d          = dat_q;
        sel_d          = sel_q;
        we_d           = we_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        ack_d          = 1'b0;
        err_d          = 1'b0;
        fault_set      = 1'b0;
        fault_set_code = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (m_wb_cyc_i && m_wb_stb_i) begin
                    adr_d   = m_wb_adr_i;
                    dat_d   = m_wb_dat_i;
                    sel_d   = m_wb_sel_i;
                    we_d    = m_wb_we_i;
                    idx_d   = req_idx;
                    cnt_d   = '0;
                    state_d = req_mapped ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                if (!m_wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_err) begin
                    err_d          = 1'b1;
                    state_d        = ST_RESP;
                    fault_set      = 1'b1;
                    fault_set_code = FC_SLVERR;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = sel_dat;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    err_d          = 1'b1;
                    state_d        = ST_RESP;
                    fault_set      = 1'b1;
                    fault_set_code = FC_TIMEOUT;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                if (!m_wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    err_d          = 1'b1;
                    state_d        = ST_RESP;
                    fault_set      = 1'b1;
                    fault_set_code = FC_UNMAPPED;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new fault arriving together with a clear wins over the clear.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_code_d  = fault_code_q;
        fault_adr_d   = fault_adr_q;
        if (fault_clr_i) begin
            fault_valid_d = 1'b0;
            fault_code_d  = 2'b00;
            fault_adr_d   = '0;
        end
        if (fault_set && (!fault_valid_q || fault_clr_i)) begin
            fault_valid_d = 1'b1;
            fault_code_d  = fault_set_code;
            fault_adr_d   = adr_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            we_q          <= 1'b0;
            idx_q         <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_code_q  <= 2'b00;
            fault_adr_q   <= '0;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            fault_valid_q <= fault_valid_d;
            fault_code_q  <= fault_code_d;
            fault_adr_q   <= fault_adr_d;
        end
    end

    assign m_wb_dat_o    = rdata_q;
    assign m_wb_ack_o    = ack_q;
    assign m_wb_err_o    = err_q;
    assign fault_valid_o = fault_valid_q;
    assign fault_code_o  = fault_code_q;
    assign fault_adr_o   = fault_adr_q;

endmodule
